// File: rtl/rv32i_pkg.sv
// Shared encodings for the rv32i_core slice: opcodes, funct3 codes, CSR
// addresses and the ALU operation set.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3, F3_XOR  = 3'd4, F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6, F3_AND  = 3'd7;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;
  localparam logic [11:0] SYS_ECALL   = 12'h000;
  localparam logic [11:0] SYS_MRET    = 12'h302;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_memory.sv
// Unified instruction/data word memory: two combinational read ports and a
// byte-enabled synchronous write port.
module rv32i_memory
  import rv32i_pkg::*;
#(
  parameter int MEM_WORDS = 65536
) (
  input  logic        clk,
  input  logic [15:0] fetch_idx,
  output logic [31:0] fetch_data,
  input  logic [15:0] data_idx,
  output logic [31:0] rdata,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata
);

  logic [31:0] m [0:MEM_WORDS-1];

  assign fetch_data = m[fetch_idx];
  assign rdata      = m[data_idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) m[data_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: fetch through writeback is combinational from pc,
// and pc, register, store and CSR updates all commit on one rising edge.
module rv32i_core
  import rv32i_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  logic [31:0] pc, pc_next, instr;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  f3;
  logic [11:0] csr_addr;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rv1, rv2;
  alu_op_e     alu_op;
  logic [31:0] alu_b, alu_y;
  logic        br_taken;
  logic [31:0] mem_addr, mem_rdata, ld_word, load_val, st_data;
  logic [3:0]  st_strb, wstrb;
  logic [31:0] csr_old, csr_src, csr_new;
  logic        rd_we, csr_we, trap;
  logic [31:0] rd_val;
  logic        unused_bits;

  rv32i_memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk       (clk),
    .fetch_idx (pc[17:2]),
    .fetch_data(instr),
    .data_idx  (mem_addr[17:2]),
    .rdata     (mem_rdata),
    .wstrb     (wstrb & {4{rst}}),
    .wdata     (st_data)
  );

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign f3       = instr[14:12];
  assign rs1a     = instr[19:15];
  assign rs2a     = instr[24:20];
  assign csr_addr = instr[31:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'd0};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign rv1      = (rs1a == 5'd0) ? 32'd0 : rs[rs1a];
  assign rv2      = (rs2a == 5'd0) ? 32'd0 : rs[rs2a];

  // SUB exists only for register-register ops; OP-IMM bit 30 is immediate data
  always_comb begin
    alu_op = ALU_ADD;
    case (f3)
      F3_ADD:  alu_op = (opcode == OP_OP && instr[30]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_b = (opcode == OP_OP) ? rv2 : imm_i;
  assign alu_y = alu(alu_op, rv1, alu_b);

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (rv1 == rv2);
      F3_BNE:  br_taken = (rv1 != rv2);
      F3_BLT:  br_taken = ($signed(rv1) < $signed(rv2));
      F3_BGE:  br_taken = ($signed(rv1) >= $signed(rv2));
      F3_BLTU: br_taken = (rv1 < rv2);
      F3_BGEU: br_taken = (rv1 >= rv2);
      default: br_taken = 1'b0;
    endcase
  end

  assign mem_addr    = rv1 + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ld_word     = mem_rdata >> {mem_addr[1:0], 3'b000};
  assign unused_bits = ^mem_addr[31:18];

  always_comb begin
    load_val = mem_rdata;
    st_strb  = 4'b1111;
    st_data  = rv2;
    case (f3)
      F3_LB:   load_val = {{24{ld_word[7]}}, ld_word[7:0]};
      F3_LH:   load_val = {{16{ld_word[15]}}, ld_word[15:0]};
      F3_LW:   load_val = mem_rdata;
      F3_LBU:  load_val = {24'd0, ld_word[7:0]};
      F3_LHU:  load_val = {16'd0, ld_word[15:0]};
      default: load_val = mem_rdata;
    endcase
    case (f3)
      F3_SB: begin
        st_strb = 4'b0001 << mem_addr[1:0];
        st_data = {4{rv2[7:0]}};
      end
      F3_SH: begin
        st_strb = 4'b0011 << mem_addr[1:0];
        st_data = {2{rv2[15:0]}};
      end
      default: ;
    endcase
  end

  assign csr_old = (csr_addr == CSR_MHARTID) ? 32'd0 : csr[csr_addr];
  assign csr_src = f3[2] ? {27'd0, rs1a} : rv1;

  always_comb begin
    case (f3[1:0])
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_src;
    endcase
  end

  always_comb begin
    pc_next = pc + 32'd4;
    rd_we   = 1'b0;
    rd_val  = alu_y;
    wstrb   = 4'b0000;
    csr_we  = 1'b0;
    trap    = 1'b0;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_val = pc + 32'd4; pc_next = pc + imm_j; end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_val  = pc + 32'd4;
        pc_next = (rv1 + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
      OP_STORE:  wstrb = st_strb;
      OP_IMM, OP_OP: rd_we = 1'b1;
      OP_FENCE:  ;
      OP_SYSTEM: begin
        if (f3[1:0] != 2'b00) begin
          rd_we  = 1'b1;
          rd_val = csr_old;
          csr_we = (f3[1:0] == 2'b01) || (rs1a != 5'd0);
        end else if (f3 == 3'd0 && csr_addr == SYS_ECALL) begin
          trap    = 1'b1;
          pc_next = csr[CSR_MTVEC];
        end else if (f3 == 3'd0 && csr_addr == SYS_MRET) begin
          pc_next = csr[CSR_MEPC];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
      csr[CSR_MTVEC]  <= 32'd0;
      csr[CSR_MEPC]   <= 32'd0;
      csr[CSR_MCAUSE] <= 32'd0;
    end else begin
      pc <= pc_next;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
      if (csr_we) csr[csr_addr] <= csr_new;
      if (trap) begin
        csr[CSR_MEPC]   <= pc;
        csr[CSR_MCAUSE] <= 32'd11;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core: small hand-assembled programs preloaded into
// the memory instance, with hand-computed architectural state checked after each.
module tb_rv32i_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rv32i_core dut (.clk(clk), .rst(rst));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    dut.memory.m[addr[17:2]] <= word;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) dut.memory.m[16'(i)] <= 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
  endtask

  initial begin
    // ---- reset state plus ADDI / x0 / JAL / JALR ----
    clear_prog();
    put(32'h00, addi(5'd1, 5'd0, 12'h005));
    put(32'h04, addi(5'd2, 5'd1, 12'hFF9));
    put(32'h08, addi(5'd0, 5'd0, 12'h001));
    put(32'h0C, addi(5'd0, 5'd0, 12'h000));
    put(32'h10, enc_j(21'h8, 5'd1));
    put(32'h18, enc_i(12'h000, 5'd1, 3'd0, 5'd1, 7'h67));
    do_reset();
    check("reset_pc", dut.pc, 32'h0);
    check("reset_x1", dut.rs[1], 32'h0);
    check("reset_mtvec", dut.csr[12'h305], 32'h0);
    check("reset_mcause", dut.csr[12'h342], 32'h0);
    step(2);
    check("addi_x1", dut.rs[1], 32'h5);
    check("addi_x2_neg", dut.rs[2], 32'hFFFF_FFFE);
    step(1);
    check("x0_write_dropped", dut.rs[0], 32'h0);
    step(2);
    check("jal_link", dut.rs[1], 32'h14);
    check("jal_pc", dut.pc, 32'h18);
    step(1);
    check("jalr_pc", dut.pc, 32'h14);
    check("jalr_link_rd_eq_rs1", dut.rs[1], 32'h1C);

    // ---- stores, sub-word lanes, load-after-store ----
    clear_prog();
    put(32'h00, {20'h11223, 5'd1, 7'h37});
    put(32'h04, addi(5'd1, 5'd1, 12'h344));
    put(32'h08, addi(5'd2, 5'd0, 12'h100));
    put(32'h0C, enc_s(12'h000, 5'd1, 5'd2, 3'd2));
    put(32'h10, addi(5'd3, 5'd0, 12'hFAA));
    put(32'h14, enc_s(12'h001, 5'd3, 5'd2, 3'd0));
    put(32'h18, enc_i(12'h001, 5'd2, 3'd4, 5'd4, 7'h03));
    put(32'h1C, enc_i(12'h000, 5'd2, 3'd1, 5'd5, 7'h03));
    put(32'h20, enc_i(12'h000, 5'd2, 3'd2, 5'd6, 7'h03));
    put(32'h24, enc_i(12'h001, 5'd2, 3'd0, 5'd7, 7'h03));
    put(32'h28, enc_i(12'h002, 5'd2, 3'd5, 5'd8, 7'h03));
    do_reset();
    step(4);
    check("sw_word", dut.memory.m[16'h40], 32'h1122_3344);
    step(2);
    check("sb_lane1", dut.memory.m[16'h40], 32'h1122_AA44);
    step(5);
    check("lbu_after_sb", dut.rs[4], 32'h0000_00AA);
    check("lh_sext", dut.rs[5], 32'hFFFF_AA44);
    check("lw", dut.rs[6], 32'h1122_AA44);
    check("lb_sext", dut.rs[7], 32'hFFFF_FFAA);
    check("lhu_upper", dut.rs[8], 32'h0000_1122);

    // ---- branches and ALU ----
    clear_prog();
    put(32'h00, addi(5'd1, 5'd0, 12'hFFF));
    put(32'h04, addi(5'd2, 5'd0, 12'h001));
    put(32'h08, enc_b(13'd12, 5'd2, 5'd1, 3'd4));
    put(32'h14, enc_b(13'd12, 5'd2, 5'd1, 3'd6));
    put(32'h18, enc_b(13'd8, 5'd2, 5'd1, 3'd7));
    put(32'h20, enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3));
    put(32'h24, enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4));
    put(32'h28, enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd5));
    put(32'h2C, enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd6));
    put(32'h30, enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd7));
    put(32'h34, enc_i(12'h0F0, 5'd1, 3'd4, 5'd8, 7'h13));
    put(32'h38, enc_i(12'h01F, 5'd2, 3'd1, 5'd9, 7'h13));
    do_reset();
    step(3);
    check("blt_taken_pc", dut.pc, 32'h14);
    step(1);
    check("bltu_not_taken_pc", dut.pc, 32'h18);
    step(1);
    check("bgeu_taken_pc", dut.pc, 32'h20);
    step(7);
    check("slt", dut.rs[3], 32'h1);
    check("sltu", dut.rs[4], 32'h0);
    check("srl", dut.rs[5], 32'h7FFF_FFFF);
    check("sra", dut.rs[6], 32'hFFFF_FFFF);
    check("sub", dut.rs[7], 32'h2);
    check("xori", dut.rs[8], 32'hFFFF_FF0F);
    check("slli31", dut.rs[9], 32'h8000_0000);

    // ---- CSR access, ECALL, MRET ----
    clear_prog();
    put(32'h00, addi(5'd5, 5'd0, 12'h080));
    put(32'h04, enc_i(12'h305, 5'd5, 3'd1, 5'd0, 7'h73));
    put(32'h08, enc_j(21'h38, 5'd0));
    put(32'h40, 32'h0000_0073);
    put(32'h80, enc_i(12'h342, 5'd0, 3'd2, 5'd9, 7'h73));
    put(32'h84, enc_i(12'hF14, 5'd0, 3'd2, 5'd10, 7'h73));
    put(32'h88, 32'h3020_0073);
    do_reset();
    step(2);
    check("csrrw_mtvec", dut.csr[12'h305], 32'h80);
    step(2);
    check("ecall_pc", dut.pc, 32'h80);
    check("ecall_mepc", dut.csr[12'h341], 32'h40);
    check("ecall_mcause", dut.csr[12'h342], 32'd11);
    step(2);
    check("csrrs_read_mcause", dut.rs[9], 32'd11);
    check("csrrs_x0_no_write", dut.csr[12'h342], 32'd11);
    check("mhartid_zero", dut.rs[10], 32'h0);
    step(1);
    check("mret_pc", dut.pc, 32'h40);

    // ---- jal-style self-test program, then reset mid-run ----
    clear_prog();
    put(32'h00, addi(5'd6, 5'd0, 12'h040));
    put(32'h04, enc_i(12'h305, 5'd6, 3'd1, 5'd0, 7'h73));
    put(32'h08, addi(5'd3, 5'd0, 12'h002));
    put(32'h0C, enc_j(21'h8, 5'd4));
    put(32'h10, enc_j(21'h20, 5'd0));
    put(32'h14, addi(5'd5, 5'd0, 12'h010));
    put(32'h18, enc_b(13'h18, 5'd5, 5'd4, 3'd1));
    put(32'h1C, addi(5'd3, 5'd0, 12'h001));
    put(32'h20, addi(5'd17, 5'd0, 12'h05D));
    put(32'h24, 32'h0000_0073);
    put(32'h30, addi(5'd3, 5'd0, 12'h003));
    put(32'h34, 32'h0000_0073);
    put(32'h40, enc_j(21'h0, 5'd0));
    do_reset();
    step(5000);
    check("prog_gp_pass", dut.rs[3], 32'h1);
    check("prog_link", dut.rs[4], 32'h10);
    check("prog_a7", dut.rs[17], 32'd93);
    check("prog_mepc", dut.csr[12'h341], 32'h24);
    check("prog_handler_pc", dut.pc, 32'h40);
    rst = 1'b0;
    step(1);
    check("midrun_reset_pc", dut.pc, 32'h0);
    check("midrun_reset_gp", dut.rs[3], 32'h0);
    check("midrun_reset_mtvec", dut.csr[12'h305], 32'h0);
    check("midrun_mem_kept", dut.memory.m[16'h9], 32'h0000_0073);
    rst = 1'b1;
    step(1);
    check("restart_pc", dut.pc, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
